// File: rtl/crc_activity_monitor.sv
// Hold-filters CRC activity strobes and runs the sleep request/ack handshake with the clock controller.
// Latency: i_act -> o_ch_active 1 edge; o_ch_active -> FSM 1 edge; all outputs registered.
module crc_activity_monitor #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 5
) (
    input  logic                    i_clk,
    input  logic                    i_nreset,
    input  logic [NUM_CH-1:0]       i_act,
    input  logic [NUM_CH-1:0]       i_ch_mask,
    input  logic [NUM_CH*CNT_W-1:0] i_ch_hold,
    input  logic [CNT_W-1:0]        i_glob_hold,
    input  logic                    i_sleep_ack,
    input  logic                    i_cnt_clr,
    output logic [NUM_CH-1:0]       o_ch_active,
    output logic                    o_crc_idle,
    output logic                    o_sleep_req,
    output logic                    o_activation_pulse,
    output logic                    o_idle_pulse,
    output logic [15:0]             o_sleep_cnt
);

    typedef enum logic [1:0] {ACTIVE, DRAIN, SLEEP_REQ, SLEEP} state_t;

    state_t           state;
    logic [CNT_W-1:0] gcnt;
    logic             wake_pend;
    logic             any_act;
    logic             sleep_entry;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic             flag;

        // Mask has priority; the hold value is only sampled on a fresh load.
        always_ff @(posedge i_clk or negedge i_nreset) begin
            if (!i_nreset) begin
                cnt  <= '0;
                flag <= 1'b0;
            end else if (i_ch_mask[k]) begin
                cnt  <= '0;
                flag <= 1'b0;
            end else if (i_act[k]) begin
                cnt  <= i_ch_hold[k*CNT_W +: CNT_W];
                flag <= 1'b1;
            end else if (cnt != '0) begin
                cnt  <= cnt - CNT_W'(1);
            end else begin
                flag <= 1'b0;
            end
        end

        assign o_ch_active[k] = flag;
    end

    assign any_act     = |o_ch_active;
    assign sleep_entry = (state == SLEEP_REQ) && !any_act && i_sleep_ack;

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            state              <= ACTIVE;
            gcnt               <= '0;
            wake_pend          <= 1'b0;
            o_crc_idle         <= 1'b0;
            o_sleep_req        <= 1'b0;
            o_activation_pulse <= 1'b0;
            o_idle_pulse       <= 1'b0;
            o_sleep_cnt        <= '0;
        end else begin
            o_idle_pulse       <= 1'b0;
            wake_pend          <= 1'b0;
            // Wake pulse trails the state change by one cycle.
            o_activation_pulse <= wake_pend;

            case (state)
                ACTIVE: begin
                    if (!any_act) begin
                        state <= DRAIN;
                        gcnt  <= i_glob_hold;
                    end
                end
                DRAIN: begin
                    if (any_act) begin
                        state <= ACTIVE;
                    end else if (gcnt == '0) begin
                        state       <= SLEEP_REQ;
                        o_sleep_req <= 1'b1;
                    end else begin
                        gcnt <= gcnt - CNT_W'(1);
                    end
                end
                SLEEP_REQ: begin
                    if (any_act) begin
                        state       <= ACTIVE;
                        o_sleep_req <= 1'b0;
                    end else if (i_sleep_ack) begin
                        state        <= SLEEP;
                        o_sleep_req  <= 1'b0;
                        o_crc_idle   <= 1'b1;
                        o_idle_pulse <= 1'b1;
                    end
                end
                SLEEP: begin
                    if (any_act) begin
                        state      <= ACTIVE;
                        o_crc_idle <= 1'b0;
                        wake_pend  <= 1'b1;
                    end
                end
                default: state <= ACTIVE;
            endcase

            if (i_cnt_clr) begin
                o_sleep_cnt <= '0;
            end else if (sleep_entry && (o_sleep_cnt != 16'hFFFF)) begin
                o_sleep_cnt <= o_sleep_cnt + 16'd1;
            end
        end
    end

endmodule
